bsync_align_ctrl: RTL and testbench



---
 rtl/bsync_ctrl_pkg.sv | 32 +++
 rtl/bsync_timeout_cnt.sv | 30 +++
 rtl/bsync_align_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_bsync_align_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsync_ctrl_pkg.sv
// Shared types for the BSYNC alignment sequencer: state and error encodings
// as seen by the AXI register map.
package bsync_ctrl_pkg;

    localparam int STATE_WIDTH = 3;
    localparam int ERR_WIDTH   = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE      = 3'd0,
        ST_RESET_GEN = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_CALIB     = 3'd3,
        ST_VERIFY    = 3'd4,
        ST_LOCKED    = 3'd5,
        ST_FAIL      = 3'd6
    } state_t;

    typedef enum logic [ERR_WIDTH-1:0] {
        ERR_NONE            = 3'd0,
        ERR_CAPTURE_TIMEOUT = 3'd1,
        ERR_CALIB_TIMEOUT   = 3'd2,
        ERR_ALIGNMENT       = 3'd3,
        ERR_RATIO           = 3'd4,
        ERR_LOST_LOCK       = 3'd5
    } err_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_RESET_GEN) || (s == ST_CAPTURE) ||
               (s == ST_CALIB)     || (s == ST_VERIFY);
    endfunction

endpackage

// File: rtl/bsync_timeout_cnt.sv
// Saturating per-state cycle counter; expired is asserted while the count
// equals the limit selected by the sequencer.
module bsync_timeout_cnt #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = en && (cnt_q == limit);

endmodule

// File: rtl/bsync_align_ctrl.sv
// Drives bsync_generator through reset, capture, calibration and verified
// lock, retrying failed attempts and reporting status to the register map.
module bsync_align_ctrl
    import bsync_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES    = 16,
    parameter int unsigned TIMEOUT_WIDTH   = 24,
    parameter int unsigned CAPTURE_TIMEOUT = 32'h00FF_FFFF,
    parameter int unsigned CALIB_TIMEOUT   = 32'h00FF_FFFF,
    parameter int unsigned VERIFY_CYCLES   = 4096,
    parameter int unsigned MAX_RETRIES     = 3,
    parameter int unsigned MIN_RATIO       = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   gen_captured,
    input  logic                   gen_ready,
    input  logic                   gen_alignment_error,
    input  logic [15:0]            gen_ratio,
    output logic                   gen_rstn,
    output logic                   gen_direction,
    output logic                   gen_disable_internal,
    output logic                   busy,
    output logic                   locked,
    output logic                   error,
    output logic [ERR_WIDTH-1:0]   error_code,
    output logic [3:0]             retry_count,
    output logic [15:0]            ratio_latched,
    output logic [STATE_WIDTH-1:0] state
);

    state_t state_q, state_d;
    err_t   err_q, err_d, fail_code;
    logic [3:0]  retry_q, retry_d;
    logic [15:0] ratio_q, ratio_d;
    logic        attempt_fail;
    logic        gen_rstn_q, gen_dir_q, gen_dis_q, busy_q, locked_q, error_q;

    logic [TIMEOUT_WIDTH-1:0] limit;
    logic                     expired;

    always_comb begin
        limit = '0;
        case (state_q)
            ST_RESET_GEN: limit = TIMEOUT_WIDTH'(RESET_CYCLES - 1);
            ST_CAPTURE:   limit = TIMEOUT_WIDTH'(CAPTURE_TIMEOUT);
            ST_CALIB:     limit = TIMEOUT_WIDTH'(CALIB_TIMEOUT);
            ST_VERIFY:    limit = TIMEOUT_WIDTH'(VERIFY_CYCLES - 1);
            default:      limit = '0;
        endcase
    end

    // Every state entry is a state change, so that alone restarts the count.
    bsync_timeout_cnt #(
        .WIDTH (TIMEOUT_WIDTH)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_d != state_q),
        .en      (is_busy(state_q)),
        .limit   (limit),
        .expired (expired)
    );

    // NOTE: every signal assigned here gets a default first, so no path through
    // the block can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        retry_d      = retry_q;
        ratio_d      = ratio_q;
        fail_code    = ERR_NONE;
        attempt_fail = 1'b0;

        case (state_q)
            ST_RESET_GEN: if (expired) state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                if (gen_captured) begin
                    state_d = ST_CALIB;
                end else if (expired) begin
                    attempt_fail = 1'b1;
                    fail_code    = ERR_CAPTURE_TIMEOUT;
                end
            end
            ST_CALIB: begin
                if (gen_ready) begin
                    if (gen_ratio < 16'(MIN_RATIO)) begin
                        attempt_fail = 1'b1;
                        fail_code    = ERR_RATIO;
                    end else begin
                        state_d = ST_VERIFY;
                        ratio_d = gen_ratio;
                    end
                end else if (expired) begin
                    attempt_fail = 1'b1;
                    fail_code    = ERR_CALIB_TIMEOUT;
                end
            end
            ST_VERIFY: begin
                if (gen_alignment_error) begin
                    attempt_fail = 1'b1;
                    fail_code    = ERR_ALIGNMENT;
                end else if (expired) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (gen_alignment_error || !gen_ready) begin
                    state_d = ST_FAIL;
                    err_d   = ERR_LOST_LOCK;
                end
            end
            ST_IDLE, ST_FAIL: begin
            end
            default: state_d = ST_IDLE;
        endcase

        if (attempt_fail) begin
            if (retry_q < 4'(MAX_RETRIES)) begin
                retry_d = retry_q + 4'd1;
                state_d = ST_RESET_GEN;
            end else begin
                state_d = ST_FAIL;
                err_d   = fail_code;
            end
        end

        if (start && !is_busy(state_q) && (state_q != ST_RESET_GEN)) begin
            retry_d = '0;
            err_d   = ERR_NONE;
            state_d = ST_RESET_GEN;
        end

        // Abort freezes the status registers so software can still read why.
        if (abort) begin
            state_d = ST_IDLE;
            err_d   = err_q;
            retry_d = retry_q;
            ratio_d = ratio_q;
        end
    end

    // Generator controls come straight from flops decoded off the next state,
    // so nothing combinational ever reaches the generator pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            err_q      <= ERR_NONE;
            retry_q    <= '0;
            ratio_q    <= '0;
            gen_rstn_q <= 1'b0;
            gen_dir_q  <= 1'b0;
            gen_dis_q  <= 1'b1;
            busy_q     <= 1'b0;
            locked_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            retry_q    <= retry_d;
            ratio_q    <= ratio_d;
            gen_rstn_q <= (state_d == ST_CAPTURE) || (state_d == ST_CALIB) ||
                          (state_d == ST_VERIFY)  || (state_d == ST_LOCKED);
            gen_dir_q  <= (state_d == ST_CAPTURE) || (state_d == ST_CALIB) ||
                          (state_d == ST_VERIFY)  || (state_d == ST_LOCKED);
            gen_dis_q  <= (state_d != ST_LOCKED);
            busy_q     <= is_busy(state_d);
            locked_q   <= (state_d == ST_LOCKED);
            error_q    <= (state_d == ST_FAIL);
        end
    end

    assign gen_rstn             = gen_rstn_q;
    assign gen_direction        = gen_dir_q;
    assign gen_disable_internal = gen_dis_q;
    assign busy                 = busy_q;
    assign locked               = locked_q;
    assign error                = error_q;
    assign error_code           = err_q;
    assign retry_count          = retry_q;
    assign ratio_latched        = ratio_q;
    assign state                = state_q;

endmodule

// File: tb/tb_bsync_align_ctrl.sv
// Self-checking bench: a cycle-level generator stand-in plus an arithmetic
// outcome predictor for each start-to-LOCKED/FAIL run.
module tb_bsync_align_ctrl;

    localparam int RC   = 4;
    localparam int CT   = 100;
    localparam int CALT = 150;
    localparam int VC   = 64;
    localparam int MAXR = 2;
    localparam int MINR = 2;

    logic        clk, rst, start, abort;
    logic        gen_captured, gen_ready, gen_alignment_error;
    logic [15:0] gen_ratio;
    logic        gen_rstn, gen_direction, gen_disable_internal;
    logic        busy, locked, error;
    logic [2:0]  error_code;
    logic [3:0]  retry_count;
    logic [15:0] ratio_latched;
    logic [2:0]  state;

    bsync_align_ctrl #(
        .RESET_CYCLES    (RC),
        .TIMEOUT_WIDTH   (24),
        .CAPTURE_TIMEOUT (CT),
        .CALIB_TIMEOUT   (CALT),
        .VERIFY_CYCLES   (VC),
        .MAX_RETRIES     (MAXR),
        .MIN_RATIO       (MINR)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .abort                (abort),
        .gen_captured         (gen_captured),
        .gen_ready            (gen_ready),
        .gen_alignment_error  (gen_alignment_error),
        .gen_ratio            (gen_ratio),
        .gen_rstn             (gen_rstn),
        .gen_direction        (gen_direction),
        .gen_disable_internal (gen_disable_internal),
        .busy                 (busy),
        .locked               (locked),
        .error                (error),
        .error_code           (error_code),
        .retry_count          (retry_count),
        .ratio_latched        (ratio_latched),
        .state                (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Per-attempt generator behaviour, in cycles since gen_rstn was released.
    int cap_d[3], rdy_d[3], ratio_v[3], ae_d[3];
    int age = 0;
    int att = -1;
    bit force_ae = 1'b0;
    bit dis_low_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_att(input int a, input int cap, input int rdy, input int ratio, input int ae);
        cap_d[a] = cap; rdy_d[a] = rdy; ratio_v[a] = ratio; ae_d[a] = ae;
    endtask

    // One clock: advance past the edge, then update the generator stand-in.
    task automatic tick();
        int a;
        @(posedge clk);
        #1;
        if (!gen_rstn) begin
            age = 0;
        end else begin
            if (age == 0) att++;
            age++;
        end
        a = (att < 0) ? 0 : ((att > 2) ? 2 : att);
        gen_captured        = gen_rstn && (age >= cap_d[a]);
        gen_ready           = gen_rstn && (age >= rdy_d[a]);
        gen_alignment_error = (gen_rstn && (age == ae_d[a])) || force_ae;
        gen_ratio           = 16'(ratio_v[a]);
        if (!gen_disable_internal) dis_low_seen = 1'b1;
    endtask

    // Outcome of a run from the start edge, from the sequencing rules alone:
    // each attempt begins with RC reset cycles, then the first rule violated
    // decides when (edge offset) and why it ends.
    task automatic predict(output bit lk, output int code, output int rc, output int cyc);
        int s, e, f, c;
        s = 0; lk = 0; code = 0; rc = 0; cyc = 0;
        for (int a = 0; a <= MAXR; a++) begin
            e = s + RC;
            if (cap_d[a] > CT + 1) begin
                f = e + CT + 1; c = 1;
            end else if (rdy_d[a] - cap_d[a] - 1 > CALT) begin
                f = e + cap_d[a] + CALT + 1; c = 2;
            end else if (ratio_v[a] < MINR) begin
                f = e + rdy_d[a]; c = 4;
            end else if ((ae_d[a] - rdy_d[a] >= 1) && (ae_d[a] - rdy_d[a] <= VC)) begin
                f = e + ae_d[a]; c = 3;
            end else begin
                lk = 1; code = 0; rc = a; cyc = e + rdy_d[a] + VC;
                return;
            end
            if (a == MAXR) begin
                lk = 0; code = c; rc = a; cyc = f;
                return;
            end
            s = f;
        end
    endtask

    task automatic run_scenario(input string name);
        bit lk, done;
        int code, rc, cyc, n;
        predict(lk, code, rc, cyc);
        att = -1;
        dis_low_seen = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        done = 1'b0;
        while (n < 3000) begin
            if (locked || error) begin
                done = 1'b1;
                break;
            end
            tick();
            n++;
        end
        check({name, ".finished"}, 32'(done), 32'd1);
        check({name, ".state"}, 32'(state), lk ? 32'd5 : 32'd6);
        check({name, ".error_code"}, 32'(error_code), 32'(code));
        check({name, ".retry_count"}, 32'(retry_count), 32'(rc));
        check({name, ".cycles"}, 32'(n), 32'(cyc));
        check({name, ".attempts"}, 32'(att + 1), 32'(rc + 1));
        check({name, ".dis_low_seen"}, 32'(dis_low_seen), 32'(lk));
        if (lk) check({name, ".ratio_latched"}, 32'(ratio_latched), 32'(ratio_v[rc]));
    endtask

    task automatic check_reset_values(input string name);
        check({name, ".state"}, 32'(state), 32'd0);
        check({name, ".gen_rstn"}, 32'(gen_rstn), 32'd0);
        check({name, ".gen_direction"}, 32'(gen_direction), 32'd0);
        check({name, ".gen_disable_internal"}, 32'(gen_disable_internal), 32'd1);
        check({name, ".busy"}, 32'(busy), 32'd0);
        check({name, ".locked"}, 32'(locked), 32'd0);
        check({name, ".error"}, 32'(error), 32'd0);
        check({name, ".error_code"}, 32'(error_code), 32'd0);
        check({name, ".retry_count"}, 32'(retry_count), 32'd0);
        check({name, ".ratio_latched"}, 32'(ratio_latched), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        gen_captured = 1'b0; gen_ready = 1'b0; gen_alignment_error = 1'b0; gen_ratio = '0;
        for (int a = 0; a < 3; a++) set_att(a, 10, 100, 8, 0);
        #2;
        check_reset_values("por");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) tick();
        check("idle_hold.state", 32'(state), 32'd0);

        // Nominal lock
        run_scenario("nominal");
        check("nominal.gen_direction", 32'(gen_direction), 32'd1);
        check("nominal.gen_rstn", 32'(gen_rstn), 32'd1);
        check("nominal.busy", 32'(busy), 32'd0);

        // Lost lock: one alignment-error pulse while LOCKED
        force_ae = 1'b1;
        tick();
        force_ae = 1'b0;
        check("lost_lock.still_locked", 32'(locked), 32'd1);
        tick();
        check("lost_lock.state", 32'(state), 32'd6);
        check("lost_lock.error_code", 32'(error_code), 32'd5);
        check("lost_lock.gen_disable_internal", 32'(gen_disable_internal), 32'd1);
        check("lost_lock.error", 32'(error), 32'd1);

        // Capture never happens
        for (int a = 0; a < 3; a++) set_att(a, 1000, 2000, 8, 0);
        run_scenario("capture_timeout");

        // Calibration never completes
        for (int a = 0; a < 3; a++) set_att(a, 5, 400, 8, 0);
        run_scenario("calib_timeout");

        // Ratio below minimum on every attempt
        for (int a = 0; a < 3; a++) set_att(a, 10, 40, 1, 0);
        run_scenario("ratio_small");

        // Alignment error on attempt 0 only
        set_att(0, 10, 100, 8, 105);
        set_att(1, 12, 50, 5, 0);
        set_att(2, 12, 50, 5, 0);
        run_scenario("retry_then_lock");

        // Limits hit exactly: capture on the last allowed cycle, error on the
        // last VERIFY cycle, ready on the last CALIB cycle, ratio == minimum
        set_att(0, CT + 1, 150, 3, 150 + VC);
        set_att(1, 5, 5 + CALT + 1, MINR, 0);
        set_att(2, 5, 20, 9, 0);
        run_scenario("boundary_pass");

        // One past each limit
        set_att(0, CT + 2, CT + 50, 8, 0);
        set_att(1, 5, 5 + CALT + 2, 8, 0);
        set_att(2, 5, 20, MINR - 1, 0);
        run_scenario("boundary_fail");

        // Randomised attempts
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 3; a++) begin
                int cap, rdy;
                cap = int'($urandom_range(1, CT + 3));
                rdy = cap + int'($urandom_range(1, CALT + 3));
                set_att(a, cap, rdy, int'($urandom_range(0, 10)),
                        ($urandom_range(0, 1) == 1) ? rdy + int'($urandom_range(0, VC + 3)) : 0);
            end
            run_scenario($sformatf("random%0d", r));
        end

        // Abort together with start while in CALIB of the second attempt
        set_att(0, 10, 100, 8, 103);
        set_att(1, 10, 100, 8, 0);
        att = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!((att == 1) && (state == 3'd3)) && (n < 3000)) begin
            tick();
            n++;
        end
        check("abort.reached_calib", 32'(state), 32'd3);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort.state", 32'(state), 32'd0);
        check("abort.gen_rstn", 32'(gen_rstn), 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.retry_count", 32'(retry_count), 32'd1);
        check("abort.error_code", 32'(error_code), 32'd0);
        tick();
        check("abort.stays_idle", 32'(state), 32'd0);

        // Asynchronous reset in the middle of VERIFY
        set_att(0, 10, 100, 8, 0);
        att = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while ((state != 3'd4) && (n < 3000)) begin
            tick();
            n++;
        end
        repeat (10) tick();
        check("async_rst.in_verify", 32'(state), 32'd4);
        check("async_rst.ratio_before", 32'(ratio_latched), 32'd8);
        #3 rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        #2 rst = 1'b0;
        tick();
        check("async_rst.idle_after", 32'(state), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
